// File: rtl/key_debounce.sv
// Push-button conditioner: synchronizes the raw active-low KEY input,
// filters contact bounce, and emits single-cycle press/release pulses.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic out,
    output logic press,
    output logic release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        STABLE_UP,
        WAIT_DOWN,
        STABLE_DOWN,
        WAIT_UP
    } state_t;

    logic          sync1;
    logic          sync2;
    state_t        state;
    logic [CW-1:0] cnt;

    // Two-flop synchronizer; idles high so an unpressed key is the reset view
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= in;
            sync2 <= sync1;
        end
    end

    // Debounce FSM: count agreeing samples, flip out and pulse on the last one
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= STABLE_UP;
            cnt           <= '0;
            out           <= 1'b1;
            press         <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            press         <= 1'b0;
            release_pulse <= 1'b0;
            unique case (state)
                STABLE_UP: begin
                    if (!sync2) begin
                        state <= WAIT_DOWN;
                        cnt   <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_DOWN: begin
                    if (sync2) begin
                        state <= STABLE_UP;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state <= STABLE_DOWN;
                        cnt   <= '0;
                        out   <= 1'b0;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STABLE_DOWN: begin
                    if (sync2) begin
                        state <= WAIT_UP;
                        cnt   <= CW'(1);
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_UP: begin
                    if (!sync2) begin
                        state <= STABLE_DOWN;
                        cnt   <= '0;
                    end else if (cnt == LAST) begin
                        state         <= STABLE_UP;
                        cnt           <= '0;
                        out           <= 1'b1;
                        release_pulse <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= STABLE_UP;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/key_debounce.md
# key_debounce

Upstream conditioning stage for the board push-buttons: it synchronizes the raw asynchronous, active-low KEY input into the clock domain and filters contact bounce. It drives a clean, glitch-free, active-low key level into the existing key press-detect FSM, which takes the key level on its `in` port. It also gives single-cycle press and release pulses to consumers that want edges directly.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 250000 (5 ms at 50 MHz): number of consecutive synchronized samples that must disagree with `out` before `out` changes. Legal range ≥ 2.

Ports:
- `clk`  input  1  single system clock; all state updates on posedge.
- `reset`  input  1  synchronous, active-high reset; sampled on posedge `clk`.
- `in`  input  1  raw KEY pin, active-low (0 = pressed); asynchronous to `clk`.
- `out`  output  1  debounced key level, active-low (0 = pressed); registered.
- `press`  output  1  one-cycle pulse when `out` falls 1→0; registered.
- `release`  output  1  one-cycle pulse when `out` rises 0→1; registered.

## Operation
- Two-flop synchronizer `in` → `sync1` → `sync2`. Only `sync2` feeds the logic.
- The counter is `$clog2(DEBOUNCE_CYCLES+1)` bits wide and unsigned. It saturates by construction and never wraps.
- States:
  - `STABLE_UP`: `out`=1.
  - `WAIT_DOWN`: `out`=1.
  - `STABLE_DOWN`: `out`=0.
  - `WAIT_UP`: `out`=0.
- `STABLE_UP`: if `sync2`==0, go to `WAIT_DOWN` with cnt←1. Otherwise stay, cnt←0.
- `WAIT_DOWN`:
  - If `sync2`==1 (bounce), go to `STABLE_UP` with cnt←0. No output change.
  - Else if cnt==DEBOUNCE_CYCLES−1, go to `STABLE_DOWN`, cnt←0, `out`←0, `press`←1.
  - Else cnt←cnt+1.
- `STABLE_DOWN` and `WAIT_UP` mirror the two rules above with polarity swapped. The terminal transition sets `out`←1 and `release`←1.
- `press` and `release` are 1 for exactly the single cycle following the transition edge, then return to 0. They are never both 1.
- A held key produces exactly one `press`. No auto-repeat.
- Reset, synchronous and taking priority over everything:
  - `sync1`=`sync2`=1
  - state=`STABLE_UP`, cnt=0
  - `out`=1, `press`=0, `release`=0
- Reset behaves the same if asserted mid-count. An in-progress count is discarded.

## Timing
- Edge 0 is the first posedge at which `sync1` captures a new stable `in` value.
- `sync2` reflects that value after edge 1. The first counted sample is at edge 2.
- `out`, `press` and `release` change after edge DEBOUNCE_CYCLES+1, giving a total latency of DEBOUNCE_CYCLES+2 edges from the raw change.
- A pulse on `sync2` lasting fewer than DEBOUNCE_CYCLES consecutive cycles is rejected.
  - This corresponds to a raw `in` glitch spanning fewer than DEBOUNCE_CYCLES capture edges.
  - A pulse lasting exactly DEBOUNCE_CYCLES cycles is accepted.
- If `in` is held low through reset, the press is detected normally after reset deasserts. The first edge with `reset`=0 is edge 0.
- Outputs are glitch-free registers and feed the press-detect FSM directly.

## Test plan
All scenarios run with DEBOUNCE_CYCLES=4.
- Reset 3 cycles with `in`=1, then hold → `out`=1, `press`=0 and `release`=0 on every cycle.
- `in` 1→0 before edge 0, then held → `out` stays 1 through edge 4 and goes 0 after edge 5. `press`=1 only between edges 5 and 6. `release` stays 0.
- Bounce: `in` low for capture edges 0–2 only, then 1 → `out` stays 1 and `press` never asserts. Repeating with `in` low for edges 0–3 gives `out`=0 after edge 5.
- Release after a stable press: `in` 0→1 before edge 0 → `out`=1 after edge 5. `release` is high for one cycle. `press` is 0 throughout.
- Reset asserted for 1 cycle while in `WAIT_DOWN` with cnt=2 and `in` still 0 → `out`=1 and `press`=0 during reset. After deassert, `out`=0 after edge 5, counted from the first non-reset edge.
- `in` held 0 for 20 cycles → exactly one `press` pulse. `out` is 0 from edge 5 to the end.
